// File: rtl/seven_segment_reader.sv
// seven_segment_reader: receive side of the 7-segment digit interface.
// Samples the tens/ones segment buses, waits for STABLE_CYCLES identical
// samples, decodes the pattern to 0..30 and pulses valid (or flags err).
// Build option: define SEG_ACTIVE_LOW_EN for common-anode (inverted) buses.
module seven_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [6:0] tens_digit,
    input  logic [6:0] ones_digit,
    output logic [4:0] number,
    output logic       valid,
    output logic       err,
    output logic       locked
);

    typedef enum logic [1:0] {SEEK, COUNT, ACCEPT, LOCKED} state_t;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic [13:0] sample_q, sample_d, sample_new;
    logic [6:0]  tens_seg, ones_seg;
    logic [4:0]  number_d;
    logic        valid_d, err_d, locked_d;
    logic        same;
    logic        tens_ok, ones_ok, accept_ok;
    logic [1:0]  tens_val;
    logic [3:0]  ones_val;
    logic [5:0]  value;

`ifdef SEG_ACTIVE_LOW_EN
    assign tens_seg = ~tens_digit;
    assign ones_seg = ~ones_digit;
`else
    assign tens_seg = tens_digit;
    assign ones_seg = ones_digit;
`endif

    assign sample_new = {tens_seg, ones_seg};
    assign same       = (sample_new == sample_q);
    assign cnt_inc    = (cnt_q >= STABLE_CNT) ? STABLE_CNT : cnt_q + 4'd1;

    // Tens pattern decode of the held sample
    always_comb begin
        tens_ok  = 1'b1;
        tens_val = 2'd0;
        case (sample_q[13:7])
            7'b0000000: tens_val = 2'd0;
            7'b0110000: tens_val = 2'd1;
            7'b1101101: tens_val = 2'd2;
            7'b1111001: tens_val = 2'd3;
            default:    tens_ok  = 1'b0;
        endcase
    end

    // Ones pattern decode of the held sample
    always_comb begin
        ones_ok  = 1'b1;
        ones_val = 4'd0;
        case (sample_q[6:0])
            7'b1111110: ones_val = 4'd0;
            7'b0110000: ones_val = 4'd1;
            7'b1101101: ones_val = 4'd2;
            7'b1111001: ones_val = 4'd3;
            7'b0110011: ones_val = 4'd4;
            7'b1011011: ones_val = 4'd5;
            7'b1011111: ones_val = 4'd6;
            7'b1110000: ones_val = 4'd7;
            7'b1111111: ones_val = 4'd8;
            7'b1110011: ones_val = 4'd9;
            default:    ones_ok  = 1'b0;
        endcase
    end

    assign value     = 6'(tens_val) * 6'd10 + 6'(ones_val);
    assign accept_ok = tens_ok && ones_ok && !(tens_val == 2'd3 && ones_val != 4'd0);

    // Next-state, counter, sample register and output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        number_d = number;
        valid_d  = 1'b0;
        err_d    = err;
        locked_d = locked;
        if (sample_en) begin
            case (state_q)
                SEEK: begin
                    sample_d = sample_new;
                    cnt_d    = 4'd1;
                    state_d  = (STABLE_CNT <= 4'd1) ? ACCEPT : COUNT;
                end
                COUNT, LOCKED: begin
                    sample_d = sample_new;
                    if (same) begin
                        cnt_d = cnt_inc;
                        if (state_q == COUNT && cnt_inc == STABLE_CNT)
                            state_d = ACCEPT;
                    end else begin
                        cnt_d    = 4'd1;
                        locked_d = 1'b0;
                        state_d  = (STABLE_CNT <= 4'd1) ? ACCEPT : COUNT;
                    end
                end
                ACCEPT: begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    if (accept_ok) begin
                        number_d = value[4:0];
                        valid_d  = 1'b1;
                        err_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEEK;
            cnt_q    <= '0;
            sample_q <= '0;
            number   <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            number   <= number_d;
            valid    <= valid_d;
            err      <= err_d;
            locked   <= locked_d;
        end
    end

endmodule
